we_seq_gen: RTL and testbench

WE_SEQ_GEN -- requirements
Module: we_seq_gen

---
 rtl/we_seq_gen.sv | 166 ++++++++++++++++
 tb/tb_we_seq_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/we_seq_gen.sv
// we_seq_gen: plays back a stored pattern of (w,e) symbol pairs toward the
// w/e sequence-detector FSMs, with repeat passes, abort and error pulses.
// LEN_W must be wide enough that 2**LEN_W > MAX_LEN.
module we_seq_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [2*MAX_LEN-1:0] load_data,
  input  logic [LEN_W-1:0]     load_len,
  input  logic                 start,
  input  logic [LEN_W-1:0]     repeat_cnt,
  input  logic                 abort,
  output logic                 w,
  output logic                 e,
  output logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_idx;
  logic [LEN_W-1:0]     r_pass;
  logic                 r_w;
  logic                 r_e;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  state_t               w_nxtState;
  logic [2*MAX_LEN-1:0] w_nxtPattern;
  logic [LEN_W-1:0]     w_nxtLen;
  logic [LEN_W-1:0]     w_nxtIdx;
  logic [LEN_W-1:0]     w_nxtPass;
  logic                 w_nxtValid;
  logic                 w_nxtDone;
  logic                 w_nxtErr;
  logic [1:0]           w_sym;
  logic                 w_loadLegal;
  logic                 w_lastSym;

  // r_pass counts passes still to come after the current one, so a
  // repeat_cnt of all-ones never needs a wider counter.
  assign w_loadLegal = (load_len != '0) && (load_len <= LEN_W'(MAX_LEN));
  assign w_lastSym   = (r_idx == r_len - LEN_W'(1));

  // Next-state and next-output decode; abort outranks everything in PLAY,
  // and load outranks start outside PLAY.
  always_comb begin
    w_nxtState   = r_state;
    w_nxtPattern = r_pattern;
    w_nxtLen     = r_len;
    w_nxtIdx     = r_idx;
    w_nxtPass    = r_pass;
    w_nxtValid   = 1'b0;
    w_nxtDone    = 1'b0;
    w_nxtErr     = 1'b0;
    case (r_state)
      IDLE, ARMED: begin
        if (load) begin
          if (w_loadLegal) begin
            w_nxtPattern = load_data;
            w_nxtLen     = load_len;
            w_nxtState   = ARMED;
          end else begin
            w_nxtErr = 1'b1;
          end
        end else if (start) begin
          if (r_state == ARMED) begin
            w_nxtState = PLAY;
            w_nxtIdx   = '0;
            w_nxtPass  = repeat_cnt;
            w_nxtValid = 1'b1;
          end else begin
            w_nxtErr = 1'b1;
          end
        end
      end
      PLAY: begin
        if (abort) begin
          w_nxtState = ARMED;
          w_nxtIdx   = '0;
          w_nxtPass  = '0;
        end else begin
          w_nxtErr = load;
          if (w_lastSym) begin
            if (r_pass == '0) begin
              w_nxtState = ARMED;
              w_nxtIdx   = '0;
              w_nxtDone  = 1'b1;
            end else begin
              w_nxtIdx   = '0;
              w_nxtPass  = r_pass - LEN_W'(1);
              w_nxtValid = 1'b1;
            end
          end else begin
            w_nxtIdx   = r_idx + LEN_W'(1);
            w_nxtValid = 1'b1;
          end
        end
      end
      default: begin
        w_nxtState = IDLE;
      end
    endcase
  end

  // Pick the symbol about to be shown; forced to 00 when nothing is valid.
  always_comb begin
    w_sym = 2'b00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (w_nxtValid && (w_nxtIdx == LEN_W'(i))) begin
        w_sym = r_pattern[2*i +: 2];
      end
    end
  end

  // State, pattern storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pattern <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_pass    <= '0;
      r_w       <= 1'b0;
      r_e       <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxtState;
      r_pattern <= w_nxtPattern;
      r_len     <= w_nxtLen;
      r_idx     <= w_nxtIdx;
      r_pass    <= w_nxtPass;
      r_w       <= w_sym[1];
      r_e       <= w_sym[0];
      r_valid   <= w_nxtValid;
      r_busy    <= (w_nxtState == PLAY);
      r_done    <= w_nxtDone;
      r_err     <= w_nxtErr;
    end
  end

  assign w     = r_w;
  assign e     = r_e;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_we_seq_gen.sv
// Self-checking bench for we_seq_gen: each cycle's expected outputs are
// queued when the stimulus is driven and compared after the clock edge.
module tb_we_seq_gen;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] load_data;
  logic [3:0]  load_len;
  logic        start;
  logic [3:0]  repeat_cnt;
  logic        abort;
  logic        w;
  logic        e;
  logic        valid;
  logic        busy;
  logic        done;
  logic        err;

  int vectorCount;
  int miscompareCount;

  // Expected output word: {w, e, valid, busy, done, err}
  logic [5:0] expQ[$];

  localparam logic [5:0] OUT_IDLE = 6'b000000;
  localparam logic [5:0] OUT_ERR  = 6'b000001;
  localparam logic [5:0] OUT_DONE = 6'b000010;
  localparam logic [5:0] SYM_11   = 6'b111100;
  localparam logic [5:0] SYM_00   = 6'b001100;
  localparam logic [5:0] SYM_01   = 6'b011100;
  localparam logic [5:0] SYM_10   = 6'b101100;

  logic [5:0] patExp[6];

  we_seq_gen #(.MAX_LEN(8), .LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .load_len   (load_len),
    .start      (start),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
    .w          (w),
    .e          (e),
    .valid      (valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [5:0] actual, input logic [5:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got {w,e,valid,busy,done,err}=%b, expected %b", tag, actual, expected);
    end
  endtask

  // Pop the oldest expectation and compare it against the live outputs
  task automatic scoreOutput(input string tag);
    logic [5:0] expected;
    if (expQ.size() == 0) begin
      vectorCount++;
      miscompareCount++;
      $display("[TB] FAIL %s: scoreboard empty, got %b", tag, {w, e, valid, busy, done, err});
    end else begin
      expected = expQ.pop_front();
      checkOutput(tag, {w, e, valid, busy, done, err}, expected);
    end
  endtask

  // Drive one cycle of inputs, queue what must appear after the edge, check it
  task automatic applyStimulus(input string tag, input logic ld, input logic [15:0] ldata,
                               input logic [3:0] llen, input logic st, input logic [3:0] rep,
                               input logic ab, input logic [5:0] expOut);
    load       = ld;
    load_data  = ldata;
    load_len   = llen;
    start      = st;
    repeat_cnt = rep;
    abort      = ab;
    expQ.push_back(expOut);
    @(posedge clk);
    #1;
    scoreOutput(tag);
  endtask

  task automatic idleCycle(input string tag, input logic [5:0] expOut);
    applyStimulus(tag, 1'b0, 16'h0000, 4'd0, 1'b0, 4'd0, 1'b0, expOut);
  endtask

  initial begin
    vectorCount     = 0;
    miscompareCount = 0;
    patExp[0] = SYM_11;
    patExp[1] = SYM_00;
    patExp[2] = SYM_01;
    patExp[3] = SYM_00;
    patExp[4] = SYM_01;
    patExp[5] = SYM_00;
    rst_n      = 1'b0;
    load       = 1'b0;
    load_data  = '0;
    load_len   = '0;
    start      = 1'b0;
    repeat_cnt = '0;
    abort      = 1'b0;

    // Reset state
    #2;
    expQ.push_back(OUT_IDLE);
    scoreOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal loads and start with no pattern all raise err, nothing plays
    applyStimulus("len0_err", 1'b1, 16'h0113, 4'd0, 1'b0, 4'd0, 1'b0, OUT_ERR);
    applyStimulus("len9_err", 1'b1, 16'h0113, 4'd9, 1'b0, 4'd0, 1'b0, OUT_ERR);
    applyStimulus("idle_start_err", 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 1'b0, OUT_ERR);
    idleCycle("idle_quiet", OUT_IDLE);

    // Single pass of the 6-symbol pattern
    applyStimulus("load6", 1'b1, 16'h0113, 4'd6, 1'b0, 4'd0, 1'b0, OUT_IDLE);
    applyStimulus("p1_sym0", 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 1'b0, patExp[0]);
    for (int k = 1; k < 6; k++) idleCycle($sformatf("p1_sym%0d", k), patExp[k]);
    idleCycle("p1_done", OUT_DONE);
    idleCycle("p1_after", OUT_IDLE);

    // Three passes back to back; load during play errs and is ignored,
    // start during play is ignored silently
    applyStimulus("p3_sym0", 1'b0, 16'h0000, 4'd0, 1'b1, 4'd2, 1'b0, patExp[0]);
    for (int k = 1; k < 18; k++) begin
      if (k == 7)
        applyStimulus("p3_loaderr", 1'b1, 16'h0002, 4'd1, 1'b0, 4'd0, 1'b0, patExp[k % 6] | OUT_ERR);
      else if (k == 9)
        applyStimulus("p3_start_ign", 1'b0, 16'h0000, 4'd0, 1'b1, 4'd5, 1'b0, patExp[k % 6]);
      else
        idleCycle($sformatf("p3_sym%0d", k), patExp[k % 6]);
    end
    idleCycle("p3_done", OUT_DONE);
    idleCycle("p3_after", OUT_IDLE);

    // Abort on the third symbol, then abort in ARMED has no effect on start
    applyStimulus("ab_sym0", 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 1'b0, patExp[0]);
    idleCycle("ab_sym1", patExp[1]);
    idleCycle("ab_sym2", patExp[2]);
    applyStimulus("ab_stop", 1'b0, 16'h0000, 4'd0, 1'b0, 4'd0, 1'b1, OUT_IDLE);
    idleCycle("ab_nodone", OUT_IDLE);
    applyStimulus("ab_restart", 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 1'b1, patExp[0]);
    for (int k = 1; k < 6; k++) begin
      if (k == 5)
        applyStimulus("ab_lastsym", 1'b0, 16'h0000, 4'd0, 1'b0, 4'd0, 1'b0, patExp[k]);
      else
        idleCycle($sformatf("ab_sym%0d", k), patExp[k]);
    end
    // Abort on the final symbol suppresses done
    applyStimulus("ab_final_stop", 1'b0, 16'h0000, 4'd0, 1'b0, 4'd0, 1'b1, OUT_IDLE);
    idleCycle("ab_final_nodone", OUT_IDLE);

    // Single-symbol pattern, four passes, valid stays high throughout
    applyStimulus("len1_load", 1'b1, 16'h0002, 4'd1, 1'b0, 4'd0, 1'b0, OUT_IDLE);
    applyStimulus("len1_pass0", 1'b0, 16'h0000, 4'd0, 1'b1, 4'd3, 1'b0, SYM_10);
    for (int k = 1; k < 4; k++) idleCycle($sformatf("len1_pass%0d", k), SYM_10);
    idleCycle("len1_done", OUT_DONE);
    idleCycle("len1_after", OUT_IDLE);

    // Maximum repeat count gives sixteen passes
    applyStimulus("max_pass0", 1'b0, 16'h0000, 4'd0, 1'b1, 4'd15, 1'b0, SYM_10);
    for (int k = 1; k < 16; k++) idleCycle($sformatf("max_pass%0d", k), SYM_10);
    idleCycle("max_done", OUT_DONE);

    // Load and start together: load wins, nothing plays, no err
    applyStimulus("ldst_load", 1'b1, 16'h0113, 4'd6, 1'b1, 4'd0, 1'b0, OUT_IDLE);
    idleCycle("ldst_quiet", OUT_IDLE);

    // Reset on the fourth symbol clears outputs at once and forgets the pattern
    applyStimulus("rst_sym0", 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 1'b0, patExp[0]);
    for (int k = 1; k < 4; k++) idleCycle($sformatf("rst_sym%0d", k), patExp[k]);
    rst_n = 1'b0;
    #1;
    expQ.push_back(OUT_IDLE);
    scoreOutput("rst_async");
    @(posedge clk);
    #1;
    expQ.push_back(OUT_IDLE);
    scoreOutput("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("rst_start_err", 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 1'b0, OUT_ERR);
    idleCycle("rst_noplay", OUT_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
